// File: rtl/byte_pair_packer.sv
// byte_pair_packer
//   Packs a stream of bytes into 16-bit words, two bytes per word. A byte
//   flagged in_last while no byte is held becomes a padded word (upper or
//   lower byte 8'h00 depending on swap_en, out_pad=1). One output word is
//   held at a time; a new byte may be accepted on the same cycle the held
//   word is taken, so a continuous stream moves at one word per two cycles
//   (one word per cycle for single-byte padded words).
//
// Ports
//   clk, rst          : clock, async active-high reset
//   in_byte/in_valid/in_last/in_ready : upstream byte handshake
//   swap_en           : byte order for the word formed this cycle
//   out_word/out_valid/out_pad/out_ready : downstream word handshake
//   word_count        : words delivered downstream (wraps at 16 bits)
module byte_pair_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        swap_en,
  output logic [15:0] out_word,
  output logic        out_valid,
  output logic        out_pad,
  input  logic        out_ready,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {IDLE, HALF, OUT} state_t;

  state_t     state, state_nxt;
  logic [7:0] byte0;
  logic       accept;
  logic       xfer;

  assign out_valid = (state == OUT);
  // Ready whenever no word is held, or the held word leaves this cycle.
  assign in_ready  = (state != OUT) || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = in_last ? OUT : HALF;
      HALF: if (accept) state_nxt = OUT;
      OUT: begin
        // Accept and unload in the same cycle: no bubble between words.
        if (out_ready) begin
          if (accept) state_nxt = in_last ? OUT : HALF;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte capture and word formation. When HALF completes a word, byte0 is
  // read as the value held before this edge while in_byte lands alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte0    <= 8'h00;
      out_word <= 16'h0000;
      out_pad  <= 1'b0;
    end else if (accept) begin
      if (state == HALF) begin
        out_word <= swap_en ? {byte0, in_byte} : {in_byte, byte0};
        out_pad  <= 1'b0;
      end else if (in_last) begin
        // Lone final byte: its partner is padding.
        out_word <= swap_en ? {in_byte, 8'h00} : {8'h00, in_byte};
        out_pad  <= 1'b1;
      end else begin
        byte0 <= in_byte;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       word_count <= 16'h0000;
    else if (xfer) word_count <= word_count + 16'd1;
  end

endmodule

// File: tb/tb_byte_pair_packer.sv
module tb_byte_pair_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        swap_en = 1'b0;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_pad;
  logic        out_ready = 1'b0;
  logic [15:0] word_count;

  byte_pair_packer dut (
    .clk(clk), .rst(rst),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .swap_en(swap_en),
    .out_word(out_word), .out_valid(out_valid), .out_pad(out_pad), .out_ready(out_ready),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [16:0] sb[$];          // {pad, word}
  logic [15:0] n_words = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w, input logic p);
    sb.push_back({p, w});
    n_words = n_words + 16'd1;
  endtask

  // Present a byte and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] b, input logic last, input logic sw);
    int n = 0;
    in_byte = b; in_last = last; swap_en = sw; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_word_count", word_count, 16'h0000);
    @(negedge clk); #2;
    rst = 1'b0;
    n_words = 16'h0000;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Monitor: compares every downstream transfer against the scoreboard.
  logic [15:0] exp_cnt = 16'h0000;
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 16'h0000;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {15'd0, out_pad, out_word}, 32'hFFFFFFFF);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("out_word", out_word, e[15:0]);
        chk("out_pad", out_pad, e[16]);
      end
      chk("word_count", word_count, exp_cnt);
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  initial begin
    int c0;
    // Reset values, asynchronously before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_state_valid", out_valid, 1'b0);
    chk("rst_pad", out_pad, 1'b0);
    chk("rst_word", out_word, 16'h0000);
    chk("rst_count", word_count, 16'h0000);
    #9 rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    // 34,12 unswapped -> 1234, valid the cycle after the second accept
    send(8'h34, 1'b0, 1'b0);
    chk("half_no_valid", out_valid, 1'b0);
    push(16'h1234, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    chk("latency_valid", out_valid, 1'b1);
    // same bytes swapped -> 3412
    push(16'h3412, 1'b0);
    send(8'h34, 1'b0, 1'b1);
    send(8'h12, 1'b0, 1'b1);
    // single last byte -> padded
    push(16'h00AB, 1'b1);
    send(8'hAB, 1'b1, 1'b0);
    push(16'hCD00, 1'b1);
    send(8'hCD, 1'b1, 1'b1);
    // in_last ignored in HALF
    send(8'h66, 1'b0, 1'b0);
    push(16'h7766, 1'b0);
    send(8'h77, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();

    // Backpressure: hold word 2211 for 5 cycles with a byte offered.
    out_ready = 1'b0;
    send(8'h11, 1'b0, 1'b0);
    push(16'h2211, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    in_byte = 8'hEE; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_word", out_word, 16'h2211);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    c0 = cyc;
    push(16'h0201, 1'b0);
    push(16'h0403, 1'b0);
    push(16'h0605, 1'b0);
    push(16'h0807, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send(b, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    chk("stream_cycles", cyc - c0, 8);
    drain();
    chk("count_after_stream", word_count, n_words);

    // Reset while holding 55 in HALF discards it.
    send(8'h55, 1'b0, 1'b0);
    in_valid = 1'b0;
    pulse_rst();
    push(16'h0201, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    chk("count_after_rst", word_count, 16'h0001);

    // Wrap: 65536 single-byte padded words, one per cycle.
    pulse_rst();
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] b;
      b = 8'(i);
      push({8'h00, b}, 1'b1);
      send(b, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    drain();
    chk("wrap_count", word_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/byte_pair_packer.md
BYTE_PAIR_PACKER -- requirements
Module: byte_pair_packer

Interface
REQ-001 SHALL have no parameters; data widths are fixed at 8-bit in and 16-bit out.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_byte, input, 8 bits: upstream byte.
REQ-005 SHALL have port in_valid, input, 1 bit: in_byte is valid.
REQ-006 SHALL have port in_last, input, 1 bit: current byte ends the stream; qualified by in_valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the packer accepts a byte this cycle.
REQ-008 SHALL have port swap_en, input, 1 bit: byte order select for the word being completed.
REQ-009 SHALL have port out_word, output, 16 bits: packed word to the downstream swap stage.
REQ-010 SHALL have port out_valid, output, 1 bit: out_word is valid.
REQ-011 SHALL have port out_pad, output, 1 bit: out_word's second byte is padding.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts out_word.
REQ-013 SHALL have port word_count, output, 16 bits: count of words delivered downstream.

Function
REQ-014 SHALL define input accept as in_valid && in_ready, and output transfer as out_valid && out_ready.
REQ-015 SHALL implement three states: IDLE (no byte held), HALF (first byte held), OUT (word held, out_valid=1).
REQ-016 SHALL drive in_ready = (state != OUT) || out_ready, combinationally.
REQ-017 IDLE: on accept with in_last=0, SHALL store byte0 and go to HALF; on accept with in_last=1, SHALL go to OUT with a padded word; with no accept, SHALL stay in IDLE.
REQ-018 HALF: on accept, SHALL form the word from held byte0 and incoming byte1 and go to OUT; in_last is ignored in HALF; with no accept, SHALL stay in HALF holding byte0.
REQ-019 OUT with out_ready=0: SHALL hold out_word, out_pad and out_valid stable; in_ready=0.
REQ-020 OUT with out_ready=1 and no accept: SHALL go to IDLE.
REQ-021 OUT with out_ready=1 and accept: SHALL go to HALF (in_last=0) or reload OUT with a new padded word (in_last=1) in the same cycle, with no bubble and no lost byte.
REQ-022 Word format: SHALL form {byte1, byte0} when swap_en=0 and {byte0, byte1} when swap_en=1, with swap_en sampled on the cycle the word is formed.
REQ-023 Padded word: byte1 SHALL be 8'h00 and out_pad=1; for a non-padded word out_pad=0.
REQ-024 Latency: out_valid SHALL assert the cycle after the completing accept.
REQ-025 The byte0/byte1 capture and word formation SHALL use nonblocking assignment so that both bytes land intact in the same edge.
REQ-026 word_count SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 16'h0000.
REQ-027 in_byte and in_last SHALL be ignored whenever accept is false.

Reset
REQ-028 While rst=1, state SHALL be IDLE and out_valid, out_pad, out_word, word_count and the held byte SHALL be 0, asynchronously.
REQ-029 Reset mid-operation (HALF or OUT) SHALL discard the held byte or word with no output transfer.
REQ-030 After rst deasserts, in_ready SHALL be 1.

Verification
REQ-031 Bytes 8'h34 then 8'h12 with swap_en=0 -> out_word=16'h1234, out_pad=0, out_valid on the cycle after the second accept.
REQ-032 Same bytes with swap_en=1 -> out_word=16'h3412.
REQ-033 Single byte 8'hAB with in_last=1 from IDLE -> out_word=16'h00AB, out_pad=1.
REQ-034 out_ready=0 for 5 cycles in OUT -> out_word stable, in_ready=0, no byte consumed; then a stream of 8 back-to-back bytes with out_ready=1 yields 4 correct words, 1 per 2 cycles, with word_count=4.
REQ-035 Preload word_count to 16'hFFFF via 65535 transfers -> the next transfer gives 16'h0000.
REQ-036 rst pulse in HALF holding 8'h55 -> out_valid=0; next bytes 8'h01, 8'h02 -> 16'h0201.
